// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master: frames a burst of cmd_len bytes under one ss assertion.
// It streams TX bytes MSB first and pulses each received byte out on rx_valid.
module spi_master_ctrl #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int LEN_W    = 4
) (
   input  logic             clk,
   input  logic             rst_L,
   input  logic             cmd_valid,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             cmd_ready,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   output logic             busy,
   output logic             done,
   output logic             sclk,
   output logic             ss,
   output logic             mosi,
   input  logic             miso
);

   localparam int HC_W   = $clog2(CLK_DIV + 1);
   localparam int PH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int PH_W   = $clog2(PH_MAX + 1);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOAD, S_SHIFT, S_HOLD} state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [PH_W-1:0]  ph_cnt_q, ph_cnt_d;
   logic [HC_W-1:0]  hcnt_q, hcnt_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       tx_sh_q, tx_sh_d;
   logic [7:0]       rx_sh_q, rx_sh_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             done_q, done_d;
   logic             sclk_q, sclk_d;
   logic             ss_q, ss_d;
   logic             mosi_q, mosi_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             tx_ready_q, tx_ready_d;
   logic             busy_q, busy_d;

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      ph_cnt_d   = ph_cnt_q;
      hcnt_d     = hcnt_q;
      bit_cnt_d  = bit_cnt_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      done_d     = 1'b0;
      sclk_d     = sclk_q;
      ss_d       = ss_q;
      mosi_d     = mosi_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               if (cmd_len != '0) begin
                  rem_d    = cmd_len;
                  ss_d     = 1'b0;
                  ph_cnt_d = '0;
                  state_d  = S_SETUP;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_SETUP: begin
            if (ph_cnt_q == PH_W'(CS_SETUP - 1)) begin
               ph_cnt_d = '0;
               state_d  = S_LOAD;
            end else begin
               ph_cnt_d = ph_cnt_q + PH_W'(1);
            end
         end
         S_LOAD: begin
            if (tx_valid && tx_ready_q) begin
               tx_sh_d   = tx_data;
               mosi_d    = tx_data[7];
               hcnt_d    = '0;
               bit_cnt_d = 3'd0;
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (hcnt_q == HC_W'(CLK_DIV - 1)) begin
               hcnt_d = '0;
               if (!sclk_q) begin
                  // Rising phase: miso is sampled at the same edge sclk goes high.
                  sclk_d  = 1'b1;
                  rx_sh_d = {rx_sh_q[6:0], miso};
               end else begin
                  sclk_d = 1'b0;
                  if (bit_cnt_q == 3'd7) begin
                     rx_valid_d = 1'b1;
                     rx_data_d  = rx_sh_q;
                     rem_d      = rem_q - LEN_W'(1);
                     ph_cnt_d   = '0;
                     state_d    = (rem_q == LEN_W'(1)) ? S_HOLD : S_LOAD;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 3'd1;
                     tx_sh_d   = {tx_sh_q[6:0], 1'b0};
                     mosi_d    = tx_sh_q[6];
                  end
               end
            end else begin
               hcnt_d = hcnt_q + HC_W'(1);
            end
         end
         S_HOLD: begin
            if (ph_cnt_q == PH_W'(CS_HOLD - 1)) begin
               ph_cnt_d = '0;
               ss_d     = 1'b1;
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end else begin
               ph_cnt_d = ph_cnt_q + PH_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      cmd_ready_d = (state_d == S_IDLE);
      tx_ready_d  = (state_d == S_LOAD);
      busy_d      = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         state_q     <= S_IDLE;
         rem_q       <= '0;
         ph_cnt_q    <= '0;
         hcnt_q      <= '0;
         bit_cnt_q   <= 3'd0;
         tx_sh_q     <= 8'h00;
         rx_sh_q     <= 8'h00;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         done_q      <= 1'b0;
         sclk_q      <= 1'b0;
         ss_q        <= 1'b1;
         mosi_q      <= 1'b0;
         cmd_ready_q <= 1'b1;
         tx_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         ph_cnt_q    <= ph_cnt_d;
         hcnt_q      <= hcnt_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_sh_q     <= tx_sh_d;
         rx_sh_q     <= rx_sh_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         done_q      <= done_d;
         sclk_q      <= sclk_d;
         ss_q        <= ss_d;
         mosi_q      <= mosi_d;
         cmd_ready_q <= cmd_ready_d;
         tx_ready_q  <= tx_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign tx_ready  = tx_ready_q;
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign sclk      = sclk_q;
   assign ss        = ss_q;
   assign mosi      = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: stimulus pushes expected bytes and burst
// shapes; a negedge monitor pops and compares whenever the DUT reports them.
`timescale 1ns/1ps
module tb_spi_master_ctrl;
   localparam int CLK_DIV  = 2;
   localparam int CS_SETUP = 2;
   localparam int CS_HOLD  = 2;
   localparam int LEN_W    = 4;
   localparam int BYTE_CYC = 16 * CLK_DIV;
   localparam int M_ZERO = 0, M_LOOP = 1, M_SLAVE = 2;

   logic             clk = 1'b0;
   logic             rst_L = 1'b0;
   logic             cmd_valid;
   logic [LEN_W-1:0] cmd_len;
   logic             cmd_ready;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic             busy;
   logic             done;
   logic             sclk;
   logic             ss;
   logic             mosi;
   logic             miso;

   int mode = M_ZERO;
   int checks = 0;
   int failures = 0;

   logic [7:0] rx_q[$];
   int         rise_q[$];
   int         sslow_q[$];
   logic [7:0] sl_q[$];
   logic [7:0] sl_got[$];

   // Behavioural byte-wide slave: samples mosi on rise, shifts miso on fall,
   // and loads its out-buffer on the fall that ends each byte.
   logic [7:0] s_out = 8'h00;
   logic [7:0] s_in = 8'h00;
   int         s_cnt = 0;
   int         s_bytes = 0;
   int         s_seen = 0;

   assign miso = (mode == M_SLAVE) ? s_out[7] : (mode == M_LOOP) ? mosi : 1'b0;

   spi_master_ctrl #(
      .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .LEN_W(LEN_W)
   ) dut (
      .clk(clk), .rst_L(rst_L), .cmd_valid(cmd_valid), .cmd_len(cmd_len),
      .cmd_ready(cmd_ready), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
      .done(done), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      checks++;
      failures++;
      $display("FAIL %s: got %0h with nothing expected", name, act);
   endtask

   always @(posedge sclk) begin
      s_in = {s_in[6:0], mosi};
      if (s_cnt == 7) begin
         s_cnt = 0;
         s_bytes++;
         if (mode == M_SLAVE) sl_got.push_back(s_in);
      end else begin
         s_cnt++;
      end
   end

   always @(negedge sclk) begin
      if (s_bytes != s_seen) begin
         s_out = 8'h5A;
         s_seen = s_bytes;
      end else begin
         s_out = {s_out[6:0], 1'b0};
      end
   end

   int         rises = 0;
   int         ss_low = 0;
   logic       sclk_prev = 1'b0;
   logic       done_prev = 1'b0;
   logic [7:0] mexp;
   logic [7:0] sgot;

   always @(negedge clk) begin
      if (!rst_L) begin
         rises = 0;
         ss_low = 0;
         sclk_prev = 1'b0;
         done_prev = 1'b0;
      end else begin
         if (sclk && !sclk_prev) rises++;
         if (!ss) ss_low++;
         sclk_prev = sclk;
         if (rx_valid) begin
            if (rx_q.size() == 0) unexpected("rx_valid", {24'd0, rx_data});
            else begin
               mexp = rx_q.pop_front();
               chk("rx_data", {24'd0, rx_data}, {24'd0, mexp});
            end
         end
         while (sl_got.size() > 0) begin
            sgot = sl_got.pop_front();
            if (sl_q.size() == 0) unexpected("slave_rx", {24'd0, sgot});
            else begin
               mexp = sl_q.pop_front();
               chk("slave_rx", {24'd0, sgot}, {24'd0, mexp});
            end
         end
         if (done) begin
            chk("done_width", {31'd0, done_prev}, 32'd0);
            chk("busy_at_done", {31'd0, busy}, 32'd0);
            if (rise_q.size() == 0) unexpected("done", {31'd0, done});
            else begin
               chk("sclk_rises", rises, rise_q.pop_front());
               chk("ss_low_cycles", ss_low, sslow_q.pop_front());
            end
            rises = 0;
            ss_low = 0;
         end
         done_prev = done;
      end
   end

   task automatic expect_burst(input int nbytes, input int extra_load);
      rise_q.push_back(8 * nbytes);
      sslow_q.push_back(CS_SETUP + nbytes * (1 + BYTE_CYC) + extra_load + CS_HOLD);
   endtask

   task automatic issue_cmd(input logic [LEN_W-1:0] n);
      cmd_valid = 1'b1;
      cmd_len = n;
      for (int i = 0; i < 200; i++) begin
         if (cmd_ready) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      unexpected("cmd_accept_timeout", {31'd0, cmd_ready});
   endtask

   task automatic send_byte(input logic [7:0] b);
      tx_data = b;
      tx_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (tx_ready) begin
            @(posedge clk); #1;
            tx_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      tx_valid = 1'b0;
      unexpected("tx_accept_timeout", {31'd0, tx_ready});
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #1;
         if (!busy) begin
            repeat (2) @(posedge clk);
            #1;
            return;
         end
      end
      unexpected("idle_timeout", {31'd0, busy});
   endtask

   int bad;

   initial begin
      cmd_valid = 1'b0;
      cmd_len = '0;
      tx_valid = 1'b0;
      tx_data = 8'h00;
      mode = M_SLAVE;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ss", {31'd0, ss}, 32'd1);
      chk("rst_sclk", {31'd0, sclk}, 32'd0);
      chk("rst_mosi", {31'd0, mosi}, 32'd0);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
      rst_L = 1'b1;
      @(posedge clk); #1;

      // Two bytes against the slave model: slave returns its reset byte, then 0x5A.
      sl_q.push_back(8'h12); sl_q.push_back(8'h34);
      rx_q.push_back(8'h00); rx_q.push_back(8'h5A);
      expect_burst(2, 0);
      issue_cmd(4'd2);
      send_byte(8'h12);
      send_byte(8'h34);
      wait_idle();

      // Loopback single byte.
      mode = M_LOOP;
      rx_q.push_back(8'hA5);
      expect_burst(1, 0);
      issue_cmd(4'd1);
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
      chk("ss_after_accept", {31'd0, ss}, 32'd0);
      send_byte(8'hA5);
      wait_idle();

      // TX stall of 10 cycles before byte 2.
      rx_q.push_back(8'h3C); rx_q.push_back(8'hC3);
      expect_burst(2, 10);
      issue_cmd(4'd2);
      send_byte(8'h3C);
      for (int i = 0; i < 200 && !tx_ready; i++) begin
         @(posedge clk); #1;
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (sclk !== 1'b0 || ss !== 1'b0 || tx_ready !== 1'b1) bad++;
         @(posedge clk); #1;
      end
      chk("stall_bus_quiet", bad, 0);
      send_byte(8'hC3);
      wait_idle();

      // Null command.
      expect_burst(0, 0);
      rise_q[rise_q.size()-1] = 0;
      sslow_q[sslow_q.size()-1] = 0;
      issue_cmd(4'd0);
      chk("null_done", {31'd0, done}, 32'd1);
      chk("null_ss", {31'd0, ss}, 32'd1);
      chk("null_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      chk("null_done_drop", {31'd0, done}, 32'd0);
      chk("null_cmd_ready", {31'd0, cmd_ready}, 32'd1);

      // Command pulsed while busy is ignored.
      rx_q.push_back(8'h81);
      expect_burst(1, 0);
      issue_cmd(4'd1);
      send_byte(8'h81);
      cmd_valid = 1'b1;
      cmd_len = 4'd3;
      chk("busy_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      wait_idle();
      rx_q.push_back(8'h7E);
      expect_burst(1, 0);
      issue_cmd(4'd1);
      send_byte(8'h7E);
      wait_idle();

      // Reset mid-shift: no pulse may follow.
      issue_cmd(4'd1);
      send_byte(8'hA5);
      repeat (10) @(posedge clk);
      #1;
      rst_L = 1'b0;
      #1;
      chk("mid_rst_ss", {31'd0, ss}, 32'd1);
      chk("mid_rst_sclk", {31'd0, sclk}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      chk("mid_rst_mosi", {31'd0, mosi}, 32'd0);
      chk("mid_rst_rx_data", {24'd0, rx_data}, 32'd0);
      chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk); #1;
      rst_L = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      chk("post_rst_ss", {31'd0, ss}, 32'd1);

      // Recovery transaction.
      rx_q.push_back(8'h5A);
      expect_burst(1, 0);
      issue_cmd(4'd1);
      send_byte(8'h5A);
      wait_idle();

      repeat (5) @(posedge clk);
      #1;
      chk("rx_q_drained", rx_q.size(), 0);
      chk("burst_q_drained", rise_q.size(), 0);
      chk("slave_q_drained", sl_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
